cga_alu_qreg_seq: RTL and testbench

//  Parametrised Q register for the ALU multiply/divide/shift path: next generation of the 16-bit QREG.

---
 rtl/cga_alu_qreg_seq.sv | 180 ++++++++++++++++++
 tb/tb_cga_alu_qreg_seq.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/cga_alu_qreg_seq.sv
// cga_alu_qreg_seq: parametrised Q register for the ALU multiply/divide/shift path.
// It supports these operations:
//   hold, parallel load, shift left/right with serial inputs, per-lane byte swap,
//   and rotate left/right.
// A START request can run a shift or rotate as a counted sequence. The sequence
// proceeds on its own and reports its state on the BUSY/DONE handshake.
// Optional feature macro: QREG_ZDET_EN adds these outputs:
//   QZ  registered zero flag
//   QSO sticky OR of the bits shifted out during a sequence
module cga_alu_qreg_seq #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 5
) (
  input  logic             ALUCLK,
  input  logic             RESET,
  input  logic [WIDTH-1:0] F,
  input  logic [2:0]       QSEL_2_0,
  input  logic             QLI,
  input  logic             QRI,
  input  logic             START,
  input  logic [CNT_W-1:0] SHCNT,
  output logic [WIDTH-1:0] Q,
  output logic             QLO,
  output logic             QRO,
  output logic             BUSY,
`ifdef QREG_ZDET_EN
  output logic             QZ,
  output logic             QSO,
`endif
  output logic             DONE
);

  localparam logic [2:0] OP_HOLD = 3'b000;
  localparam logic [2:0] OP_LOAD = 3'b001;
  localparam logic [2:0] OP_SHL  = 3'b010;
  localparam logic [2:0] OP_SHR  = 3'b011;
  localparam logic [2:0] OP_SWAP = 3'b100;
  localparam logic [2:0] OP_ROTL = 3'b101;
  localparam logic [2:0] OP_ROTR = 3'b110;

  // Byte swap works on whole 16-bit lanes, so other widths are rejected outright
  generate
    if ((WIDTH % 16) != 0 || WIDTH < 16) begin : g_bad_width
      $error("cga_alu_qreg_seq: WIDTH must be a non-zero multiple of 16");
    end
  endgenerate

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state;
  logic [WIDTH-1:0] q;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       op_lat;
  logic             busy;
  logic             done;

  logic [2:0]       op_sel;
  logic [WIDTH-1:0] q_step;
  logic [WIDTH-1:0] q_nxt;
  logic             seq_start;

  // Next register value for a single application of op
  function automatic logic [WIDTH-1:0] apply_op(input logic [2:0]       op,
                                                input logic [WIDTH-1:0] cur,
                                                input logic [WIDTH-1:0] f,
                                                input logic             li,
                                                input logic             ri);
    logic [WIDTH-1:0] r;
    r = cur;
    case (op)
      OP_LOAD: r = f;
      OP_SHL:  r = {cur[WIDTH-2:0], li};
      OP_SHR:  r = {ri, cur[WIDTH-1:1]};
      OP_SWAP: begin
        for (int l = 0; l < WIDTH / 16; l++) begin
          r[16*l +: 16] = {cur[16*l +: 8], cur[16*l+8 +: 8]};
        end
      end
      OP_ROTL: r = {cur[WIDTH-2:0], cur[WIDTH-1]};
      OP_ROTR: r = {cur[0], cur[WIDTH-1:1]};
      default: r = cur;
    endcase
    return r;
  endfunction

  // Only shifts and rotates may run as counted sequences
  function automatic logic is_seq_op(input logic [2:0] op);
    return (op == OP_SHL) || (op == OP_SHR) || (op == OP_ROTL) || (op == OP_ROTR);
  endfunction

  // Select the active op, then decide whether this edge changes Q
  always_comb begin
    op_sel    = (state == RUN) ? op_lat : QSEL_2_0;
    q_step    = apply_op(op_sel, q, F, QLI, QRI);
    seq_start = (state == IDLE) && START && is_seq_op(QSEL_2_0) && (SHCNT != '0);
    q_nxt     = q;
    if (state == RUN) begin
      q_nxt = q_step;
    end else if (!START || !is_seq_op(QSEL_2_0)) begin
      q_nxt = q_step;
    end
  end

  // Register update and sequencer FSM; reset overrides everything
  always_ff @(posedge ALUCLK) begin
    if (RESET) begin
      state  <= IDLE;
      q      <= '0;
      cnt    <= '0;
      op_lat <= OP_HOLD;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      q <= q_nxt;
      case (state)
        IDLE: begin
          if (seq_start) begin
            op_lat <= QSEL_2_0;
            cnt    <= SHCNT;
            state  <= RUN;
            busy   <= 1'b1;
            done   <= 1'b0;
          end else begin
            busy <= 1'b0;
            done <= START;
          end
        end
        RUN: begin
          cnt <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

`ifdef QREG_ZDET_EN
  logic qz;
  logic qso;
  logic out_bit;

  // Bit leaving the register on this sequence step
  always_comb begin
    out_bit = ((op_lat == OP_SHL) || (op_lat == OP_ROTL)) ? q[WIDTH-1] : q[0];
  end

  // Zero flag follows Q; shift-out OR is cleared at each sequence start
  always_ff @(posedge ALUCLK) begin
    if (RESET) begin
      qz  <= 1'b1;
      qso <= 1'b0;
    end else begin
      qz <= (q_nxt == '0);
      if (seq_start) begin
        qso <= 1'b0;
      end else if (state == RUN) begin
        qso <= qso | out_bit;
      end
    end
  end

  assign QZ  = qz;
  assign QSO = qso;
`endif

  assign Q    = q;
  assign QLO  = q[WIDTH-1];
  assign QRO  = q[0];
  assign BUSY = busy;
  assign DONE = done;

endmodule

// File: tb/tb_cga_alu_qreg_seq.sv
// Self-checking bench for cga_alu_qreg_seq (WIDTH=16) against a behavioural model.
module tb_cga_alu_qreg_seq;

  logic        ALUCLK = 1'b0;
  logic        RESET  = 1'b1;
  logic [15:0] F      = 16'h0;
  logic [2:0]  QSEL_2_0 = 3'b000;
  logic        QLI    = 1'b0;
  logic        QRI    = 1'b0;
  logic        START  = 1'b0;
  logic [4:0]  SHCNT  = 5'd0;
  logic [15:0] Q;
  logic        QLO, QRO, BUSY, DONE;
`ifdef QREG_ZDET_EN
  logic        QZ, QSO;
`endif

  int          checks = 0;
  int          errors = 0;
  logic [15:0] mq     = 16'h0;
  logic        mqso   = 1'b0;

  cga_alu_qreg_seq #(.WIDTH(16), .CNT_W(5)) dut (
    .ALUCLK(ALUCLK), .RESET(RESET), .F(F), .QSEL_2_0(QSEL_2_0),
    .QLI(QLI), .QRI(QRI), .START(START), .SHCNT(SHCNT),
    .Q(Q), .QLO(QLO), .QRO(QRO), .BUSY(BUSY),
`ifdef QREG_ZDET_EN
    .QZ(QZ), .QSO(QSO),
`endif
    .DONE(DONE)
  );

  always #5 ALUCLK = ~ALUCLK;

  task automatic tick();
    @(posedge ALUCLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] m_op(input logic [2:0] op, input logic [15:0] q,
                                       input logic [15:0] f, input logic li, input logic ri);
    logic [15:0] r;
    case (op)
      3'd1: r = f;
      3'd2: r = (q << 1) | 16'(li);
      3'd3: r = (q >> 1) | (16'(ri) << 15);
      3'd4: r = (q << 8) | (q >> 8);
      3'd5: r = (q << 1) | (q >> 15);
      3'd6: r = (q >> 1) | (q << 15);
      default: r = q;
    endcase
    return r;
  endfunction

  function automatic logic m_is_shift(input logic [2:0] op);
    return (op == 3'd2) || (op == 3'd3) || (op == 3'd5) || (op == 3'd6);
  endfunction

  task automatic do_single(input logic [2:0] op, input logic [15:0] f,
                           input logic li, input logic ri);
    QSEL_2_0 = op; F = f; QLI = li; QRI = ri; START = 1'b0;
    tick();
    mq = m_op(op, mq, f, li, ri);
    chk("single_q", Q, mq);
    chk("single_busy", BUSY, 1'b0);
    chk("single_done", DONE, 1'b0);
    chk("single_qlo", QLO, mq[15]);
    chk("single_qro", QRO, mq[0]);
`ifdef QREG_ZDET_EN
    chk("single_qz", QZ, mq == 16'h0);
`endif
  endtask

  task automatic do_start_once(input logic [2:0] op, input logic [15:0] f, input logic [4:0] n);
    QSEL_2_0 = op; F = f; SHCNT = n; START = 1'b1;
    QLI = 1'($urandom); QRI = 1'($urandom);
    tick();
    if (!m_is_shift(op)) mq = m_op(op, mq, f, QLI, QRI);
    chk("once_q", Q, mq);
    chk("once_busy", BUSY, 1'b0);
    chk("once_done", DONE, 1'b1);
    START = 1'b0; QSEL_2_0 = 3'b000;
    tick();
    chk("once_done_clr", DONE, 1'b0);
    chk("once_busy2", BUSY, 1'b0);
    chk("once_q2", Q, mq);
  endtask

  task automatic run_seq(input logic [2:0] op, input int n, input bit noisy);
    logic ob;
    QSEL_2_0 = op; SHCNT = 5'(n); START = 1'b1;
    QLI = 1'($urandom); QRI = 1'($urandom);
    tick();
    mqso = 1'b0;
    chk("seq_start_q", Q, mq);
    chk("seq_start_busy", BUSY, 1'b1);
    chk("seq_start_done", DONE, 1'b0);
    for (int k = 1; k <= n; k++) begin
      QLI = 1'($urandom); QRI = 1'($urandom);
      if (noisy) begin
        QSEL_2_0 = 3'b001; F = 16'hFFFF; START = 1'b1; SHCNT = 5'($urandom);
      end else begin
        START = 1'b0; QSEL_2_0 = 3'($urandom); F = 16'($urandom);
      end
      tick();
      ob   = (op == 3'd2 || op == 3'd5) ? mq[15] : mq[0];
      mqso = mqso | ob;
      mq   = m_op(op, mq, 16'h0, QLI, QRI);
      chk("seq_q", Q, mq);
      chk("seq_busy", BUSY, (k < n) ? 1'b1 : 1'b0);
      chk("seq_done", DONE, (k < n) ? 1'b0 : 1'b1);
    end
`ifdef QREG_ZDET_EN
    chk("seq_qso", QSO, mqso);
    chk("seq_qz", QZ, mq == 16'h0);
`endif
    START = 1'b0; QSEL_2_0 = 3'b000;
    tick();
    chk("seq_after_done", DONE, 1'b0);
    chk("seq_after_busy", BUSY, 1'b0);
    chk("seq_after_q", Q, mq);
  endtask

  logic [2:0] rop;
  int         rsel;

  initial begin
    // Reset from power-up, then preload all ones and reset again
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    mq = 16'h0;
    do_single(3'b001, 16'hFFFF, 1'b0, 1'b0);
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    mq = 16'h0;
    chk("reset_q", Q, 16'h0000);
    chk("reset_busy", BUSY, 1'b0);
    chk("reset_done", DONE, 1'b0);
`ifdef QREG_ZDET_EN
    chk("reset_qz", QZ, 1'b1);
`endif

    // Directed single operations
    do_single(3'b001, 16'h12A5, 1'b0, 1'b0);
    chk("dir_load", Q, 16'h12A5);
    do_single(3'b100, 16'h0000, 1'b0, 1'b0);
    chk("dir_swap", Q, 16'hA512);
    do_single(3'b010, 16'h0000, 1'b1, 1'b0);
    chk("dir_shl", Q, 16'h4A25);
    do_single(3'b110, 16'h0000, 1'b0, 1'b0);
    chk("dir_rotr", Q, 16'hA512);
    do_single(3'b011, 16'h0000, 1'b0, 1'b0);
    chk("dir_shr", Q, 16'h5289);
    do_single(3'b000, 16'hFFFF, 1'b1, 1'b1);
    chk("dir_hold", Q, 16'h5289);
    do_single(3'b111, 16'hFFFF, 1'b1, 1'b1);
    chk("dir_rsvd", Q, 16'h5289);

    // Counted rotate sequence
    do_single(3'b001, 16'h0001, 1'b0, 1'b0);
    run_seq(3'b101, 4, 1'b0);
    chk("dir_seq_rotl4", Q, 16'h0010);

    // Zero count and wrap-around count
    do_start_once(3'b101, 16'h0000, 5'd0);
    chk("dir_cnt0", Q, 16'h0010);
    do_single(3'b001, 16'h0001, 1'b0, 1'b0);
    run_seq(3'b101, 17, 1'b0);
    chk("dir_rotl17", Q, 16'h0002);

    // START with a non-sequence op applies it once
    do_start_once(3'b001, 16'hBEEF, 5'd7);
    chk("dir_once_load", Q, 16'hBEEF);

    // Inputs ignored while busy
    run_seq(3'b011, 9, 1'b1);
    run_seq(3'b010, 31, 1'b1);

    // Reset in the middle of a sequence
    do_single(3'b001, 16'hC3A5, 1'b0, 1'b0);
    QSEL_2_0 = 3'b010; SHCNT = 5'd10; START = 1'b1; QLI = 1'b1;
    tick();
    START = 1'b0;
    for (int k = 0; k < 3; k++) tick();
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    mq = 16'h0;
    chk("midrst_q", Q, 16'h0000);
    chk("midrst_busy", BUSY, 1'b0);
    chk("midrst_done", DONE, 1'b0);
    run_seq(3'b011, 3, 1'b0);
    tick();
    chk("midrst_nodone", DONE, 1'b0);

    // Randomized mix of single ops, one-shot starts and sequences
    for (int i = 0; i < 40; i++) begin
      rsel = int'($urandom_range(0, 3));
      if (rsel <= 1) begin
        do_single(3'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
      end else if (rsel == 2) begin
        rop = 3'($urandom);
        if (m_is_shift(rop)) do_start_once(rop, 16'($urandom), 5'd0);
        else do_start_once(rop, 16'($urandom), 5'($urandom));
      end else begin
        case ($urandom_range(0, 3))
          0: rop = 3'b010;
          1: rop = 3'b011;
          2: rop = 3'b101;
          default: rop = 3'b110;
        endcase
        run_seq(rop, int'($urandom_range(1, 31)), 1'($urandom));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
